writeback_queue: RTL

WRITEBACK_QUEUE -- requirements
Module: writeback_queue

---
 rtl/writeback_queue.sv | 139 +++++++++++++
 1 files changed

// File: rtl/writeback_queue.sv
`default_nettype none
// ============================================================================
// Module   : writeback_queue
// Brief    : Circular FIFO merging load and ALU results onto one register-file
//            write port; optional store-to-read forwarding via WB_FORWARD_EN.
// Revision : 1.0
// ============================================================================
module writeback_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mem_valid,
    input  logic [3:0]               mem_rd,
    input  logic [31:0]              mem_wd,
    output logic                     mem_ready,
    input  logic                     alu_valid,
    input  logic [3:0]               alu_rd,
    input  logic [31:0]              alu_wd,
    output logic                     alu_ready,
    input  logic                     stall,
    output logic [3:0]               RD,
    output logic [31:0]              WD,
    output logic                     wr_enable,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    input  logic [3:0]               RS1,
    input  logic [3:0]               RS2,
    input  logic [3:0]               RS3,
    output logic                     fwd_hit1,
    output logic                     fwd_hit2,
    output logic                     fwd_hit3,
    output logic [31:0]              fwd_data1,
    output logic [31:0]              fwd_data2,
    output logic [31:0]              fwd_data3
);

    localparam int              c_AW        = $clog2(DEPTH);
    localparam logic [c_AW:0]   c_DEPTH_CNT = (c_AW + 1)'(DEPTH);

    logic [3:0]      r_rd_mem [DEPTH];
    logic [31:0]     r_wd_mem [DEPTH];
    logic [c_AW-1:0] r_head;
    logic [c_AW-1:0] r_tail;
    logic [c_AW:0]   r_count;
    logic            r_wr_enable;
    logic [3:0]      r_rd;
    logic [31:0]     r_wd;

    logic            w_full;
    logic            w_empty;
    logic            w_mem_acc;
    logic            w_alu_acc;
    logic            w_push;
    logic            w_pop;
    logic [3:0]      w_push_rd;
    logic [31:0]     w_push_wd;

    // Ready comes from the registered occupancy, so a pop on a full queue
    // only opens a slot on the following cycle.
    assign w_full    = (r_count == c_DEPTH_CNT);
    assign w_empty   = (r_count == '0);
    assign mem_ready = !rst && !w_full;
    assign alu_ready = !rst && !w_full && !mem_valid;

    assign w_mem_acc = mem_valid && mem_ready;
    assign w_alu_acc = alu_valid && alu_ready;
    assign w_push    = w_mem_acc || w_alu_acc;
    assign w_pop     = !w_empty && !stall;
    assign w_push_rd = w_mem_acc ? mem_rd : alu_rd;
    assign w_push_wd = w_mem_acc ? mem_wd : alu_wd;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_wr_enable <= 1'b0;
            r_rd        <= '0;
            r_wd        <= '0;
        end else begin
            r_wr_enable <= w_pop;
            if (w_push) begin
                r_rd_mem[r_tail] <= w_push_rd;
                r_wd_mem[r_tail] <= w_push_wd;
                r_tail           <= r_tail + c_AW'(1);
            end
            if (w_pop) begin
                r_rd   <= r_rd_mem[r_head];
                r_wd   <= r_wd_mem[r_head];
                r_head <= r_head + c_AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_AW + 1)'(1);
                2'b01:   r_count <= r_count - (c_AW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign RD        = r_rd;
    assign WD        = r_wd;
    assign wr_enable = r_wr_enable;
    assign count     = r_count;
    assign full      = w_full;
    assign empty     = w_empty;

`ifdef WB_FORWARD_EN
    // Scan oldest to youngest so the youngest matching entry wins; the write
    // port register is the fallback when nothing in the queue matches.
    function automatic logic [32:0] f_lookup(input logic [3:0] rs);
        logic [32:0]     res;
        logic [c_AW-1:0] idx;
        res = '0;
        if (r_wr_enable && (r_rd == rs)) res = {1'b1, r_wd};
        for (int k = 0; k < DEPTH; k++) begin
            idx = r_head + c_AW'(k);
            if ((k < int'(r_count)) && (r_rd_mem[idx] == rs)) res = {1'b1, r_wd_mem[idx]};
        end
        return res;
    endfunction

    assign {fwd_hit1, fwd_data1} = f_lookup(RS1);
    assign {fwd_hit2, fwd_data2} = f_lookup(RS2);
    assign {fwd_hit3, fwd_data3} = f_lookup(RS3);
`else
    logic w_unused_rs;
    assign w_unused_rs = ^{RS1, RS2, RS3};
    assign fwd_hit1    = 1'b0;
    assign fwd_hit2    = 1'b0;
    assign fwd_hit3    = 1'b0;
    assign fwd_data1   = '0;
    assign fwd_data2   = '0;
    assign fwd_data3   = '0;
`endif

endmodule
`default_nettype wire
